dlsc_pcie_s6_outbound_write_ctrl: RTL and testbench

DLSC_PCIE_S6_OUTBOUND_WRITE_CTRL -- requirements
Module: dlsc_pcie_s6_outbound_write_ctrl

---
 rtl/dlsc_pcie_s6_outbound_write_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dlsc_pcie_s6_outbound_write_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_outbound_write_ctrl.sv
// dlsc_pcie_s6_outbound_write_ctrl
//
// Controls the outbound AXI->PCIe write buffer around link and bus-master changes.
// It gates new write commands, drains or flushes outstanding writes, and holds off
// until the link is usable again.
//
// Optional feature: define DLSC_PCIE_WR_TIMEOUT_EN to enable the DRAIN timeout.
// When the timeout fires, a stuck drain becomes a forced flush and timeout_err is set.
// Without the macro, DRAIN waits indefinitely for !wr_busy or !link_up, and
// timeout_err is tied low.
//
// Parameters:
//   TIMEOUT  DRAIN cycles allowed before a forced flush (2..65536).
//   CNTB     width of flush_count.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   link_up        PCIe link up (level)
//   bus_master_en  Bus Master Enable from config space (level)
//   sw_flush       software flush request (level)
//   wr_busy        write buffer has outstanding transactions
//   wr_disable     blocks new AXI write commands
//   wr_flush       write buffer discards payload and returns SLVERR
//   ctrl_run       high only in RUN
//   flush_done     one-cycle pulse on entry to HOLD from DRAIN or FLUSH
//   timeout_err    sticky DRAIN-timeout flag
//   err_clear      clears timeout_err (a same-cycle set wins)
//   flush_count    saturating count of entries into FLUSH
module dlsc_pcie_s6_outbound_write_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNTB    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            link_up,
  input  logic            bus_master_en,
  input  logic            sw_flush,
  input  logic            wr_busy,
  output logic            wr_disable,
  output logic            wr_flush,
  output logic            ctrl_run,
  output logic            flush_done,
  output logic            timeout_err,
  input  logic            err_clear,
  output logic [CNTB-1:0] flush_count
);

  typedef enum logic [1:0] {StRun, StDrain, StFlush, StHold} state_e;

  state_e          state_q, state_d;
  logic            wr_disable_q, wr_flush_q, ctrl_run_q, flush_done_q;
  logic [CNTB-1:0] flush_count_q, flush_count_d;
  logic            timeout_set;

`ifdef DLSC_PCIE_WR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_err_q, timeout_err_d;

  // The timer reads zero on the first DRAIN cycle and counts every DRAIN cycle.
  assign timer_d = (state_q == StDrain) ? timer_q + 1'b1 : '0;

  always_comb begin
    timeout_err_d = timeout_err_q;
    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (err_clear) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign timeout_err      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StRun: begin
        // Link loss has priority over a drain request.
        if (!link_up) begin
          state_d = StFlush;
        end else if (!bus_master_en || sw_flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!wr_busy) begin
          state_d = StHold;
        end else if (!link_up) begin
          state_d = StFlush;
`ifdef DLSC_PCIE_WR_TIMEOUT_EN
        end else if (timer_q == TimerMax) begin
          state_d     = StFlush;
          timeout_set = 1'b1;
`endif
        end
      end
      StFlush: begin
        if (!wr_busy) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (link_up && bus_master_en && !sw_flush) begin
          state_d = StRun;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Saturating count of FLUSH entries from RUN or DRAIN.
  always_comb begin
    flush_count_d = flush_count_q;
    if (state_d == StFlush && state_q != StFlush && flush_count_q != {CNTB{1'b1}}) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  // Outputs are registered from the next state, which gives one cycle of latency
  // from a sampled input to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHold;
      wr_disable_q  <= 1'b1;
      wr_flush_q    <= 1'b0;
      ctrl_run_q    <= 1'b0;
      flush_done_q  <= 1'b0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_disable_q  <= (state_d != StRun);
      wr_flush_q    <= (state_d == StFlush);
      ctrl_run_q    <= (state_d == StRun);
      flush_done_q  <= (state_d == StHold) && (state_q == StDrain || state_q == StFlush);
      flush_count_q <= flush_count_d;
    end
  end

  assign wr_disable  = wr_disable_q;
  assign wr_flush    = wr_flush_q;
  assign ctrl_run    = ctrl_run_q;
  assign flush_done  = flush_done_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_write_ctrl.sv
module tb_dlsc_pcie_s6_outbound_write_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_up = 1'b1;
  logic       bus_master_en = 1'b1;
  logic       sw_flush = 1'b0;
  logic       wr_busy = 1'b0;
  logic       err_clear = 1'b0;
  logic       wr_disable, wr_flush, ctrl_run, flush_done, timeout_err;
  logic [1:0] flush_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  dlsc_pcie_s6_outbound_write_ctrl #(
    .TIMEOUT(16),
    .CNTB   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_up      (link_up),
    .bus_master_en(bus_master_en),
    .sw_flush     (sw_flush),
    .wr_busy      (wr_busy),
    .wr_disable   (wr_disable),
    .wr_flush     (wr_flush),
    .ctrl_run     (ctrl_run),
    .flush_done   (flush_done),
    .timeout_err  (timeout_err),
    .err_clear    (err_clear),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compact check of {ctrl_run, wr_disable, wr_flush, flush_done}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, ctrl_run, wr_disable, wr_flush, flush_done}, {28'd0, exp});
  endtask

  function automatic int sat_inc(input int v);
    return (v < 3) ? v + 1 : 3;
  endfunction

  initial begin
    // Reset state
    #12;
    chk_out("reset_outs", 4'b0100);
    chk("reset_cnt", {30'd0, flush_count}, 32'd0);
    chk("reset_err", {31'd0, timeout_err}, 32'd0);

    // Release and enter RUN
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("run_entry", 4'b1000);

    // Bus master disable with busy writes: drain for 10 cycles
    bus_master_en = 1'b0;
    wr_busy = 1'b1;
    tick();
    chk_out("drain_entry", 4'b0100);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out("drain_hold", 4'b0100);
    end
    wr_busy = 1'b0;
    tick();
    chk_out("drain_done", 4'b0101);
    chk("drain_cnt", {30'd0, flush_count}, 32'd0);
    tick();
    chk_out("hold_bme_low", 4'b0100);
    bus_master_en = 1'b1;
    tick();
    chk_out("run_again", 4'b1000);

    // Link drop in RUN: immediate flush
    link_up = 1'b0;
    wr_busy = 1'b1;
    tick();
    exp_cnt = sat_inc(exp_cnt);
    chk_out("link_flush", 4'b0110);
    chk("link_flush_cnt", {30'd0, flush_count}, exp_cnt);
    tick();
    chk_out("link_flush_stay", 4'b0110);
    wr_busy = 1'b0;
    tick();
    chk_out("link_flush_done", 4'b0101);
    link_up = 1'b1;
    tick();
    chk_out("link_run", 4'b1000);

    // sw_flush with writes stuck busy
    sw_flush = 1'b1;
    wr_busy = 1'b1;
    tick();
    chk_out("sw_drain", 4'b0100);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_out("sw_drain_wait", 4'b0100);
    end
    tick();
`ifdef DLSC_PCIE_WR_TIMEOUT_EN
    exp_cnt = sat_inc(exp_cnt);
    chk_out("timeout_flush", 4'b0110);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    chk("timeout_cnt", {30'd0, flush_count}, exp_cnt);
    wr_busy = 1'b0;
    tick();
    chk_out("timeout_hold", 4'b0101);
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("timeout_err_clr", {31'd0, timeout_err}, 32'd0);
`else
    chk_out("no_timeout", 4'b0100);
    chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
    wr_busy = 1'b0;
    tick();
    chk_out("no_timeout_hold", 4'b0101);
    chk("no_timeout_cnt", {30'd0, flush_count}, exp_cnt);
`endif
    sw_flush = 1'b0;
    tick();
    chk_out("sw_run", 4'b1000);

    // Busy drops on the timeout cycle: HOLD wins, no error
    sw_flush = 1'b1;
    wr_busy = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    wr_busy = 1'b0;
    tick();
    chk_out("edge_hold", 4'b0101);
    chk("edge_err", {31'd0, timeout_err}, 32'd0);
    chk("edge_cnt", {30'd0, flush_count}, exp_cnt);
    sw_flush = 1'b0;
    tick();
    chk_out("edge_run", 4'b1000);

    // Link loss while draining becomes a flush
    sw_flush = 1'b1;
    wr_busy = 1'b1;
    tick();
    link_up = 1'b0;
    tick();
    exp_cnt = sat_inc(exp_cnt);
    chk_out("drain_to_flush", 4'b0110);
    chk("drain_to_flush_cnt", {30'd0, flush_count}, exp_cnt);
    wr_busy = 1'b0;
    sw_flush = 1'b0;
    tick();
    link_up = 1'b1;
    tick();
    chk_out("d2f_run", 4'b1000);

    // Link loss beats bus-master disable in RUN; repeated flushes saturate
    for (int i = 0; i < 5; i++) begin
      link_up = 1'b0;
      bus_master_en = 1'b0;
      wr_busy = 1'b1;
      tick();
      exp_cnt = sat_inc(exp_cnt);
      chk_out("sat_flush", 4'b0110);
      chk("sat_cnt", {30'd0, flush_count}, exp_cnt);
      wr_busy = 1'b0;
      tick();
      link_up = 1'b1;
      bus_master_en = 1'b1;
      tick();
    end
    chk("sat_final", {30'd0, flush_count}, 32'd3);

    // Reset mid-flush: asynchronous abort, no flush_done
    link_up = 1'b0;
    wr_busy = 1'b1;
    tick();
    chk_out("pre_rst_flush", 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 4'b0100);
    chk("rst_async_cnt", {30'd0, flush_count}, 32'd0);
    link_up = 1'b1;
    wr_busy = 1'b0;
    tick();
    chk_out("rst_held", 4'b0100);
    rst_n = 1'b1;
    tick();
    chk_out("rst_release_run", 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
